mc_main_control: RTL and testbench
==================================

Name: mc_main_control

Overview:
- Multicycle main control FSM for the 16-bit datapath.
- Sits directly upstream of the ALU control block:
  - Decodes the 4-bit instruction opcode and sequences each instruction over 3-5 cycles.
  - Drives the 3-bit ALUop that the ALU control block combines with func[2:0] to form ALUctrl.
- Drives all other datapath strobes: PC, instruction register, memory, register file and the muxes.

Parameters:
- OPW, 4, opcode width
- AOPW, 3, ALUop width; must match the ALU control block input

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  OPW  instruction register bits [15:12], valid from DECODE onward
- zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ready  in  1  memory handshake: access completes in a cycle where it is high
- ALUop  out  AOPW  to ALU control
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  out  1 each  datapath strobes
- ALUSrcB  out  2  0=regB, 1=const 1, 2=sign-ext imm, 3=zero-ext imm
- PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target
- state_o  out  4  current state, for debug

Behaviour:
- Moore FSM: all outputs decode from the state register only. The default for every strobe is 0, ALUop=000, and all mux selects are 0.
- ALUop encoding:
  - 000=add, 001=sub, 010=R-type (use func), 011=and, 100=or, 101=slt
  - 110 and 111 are reserved and never driven.
- Opcodes:
  - 0000 R, 0001 addi, 0010 andi, 0011 ori, 0100 slti
  - 0101 lw, 0110 sw, 0111 beq, 1000 bne, 1001 j
  - 1010-1111 illegal
- States and transitions:
  - FETCH:
    - Asserts MemRead, IRWrite, ALUSrcB=1, ALUop=000, PCSource=0.
    - IRWrite and PCWrite are asserted only while mem_ready=1.
    - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE: ALUSrcB=2, ALUop=000 (branch target into ALUOut). Dispatches on opcode.
  - MEM_ADDR (lw/sw): ALUSrcA=1, ALUSrcB=2, ALUop=000. Goes to MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ:
    - Asserts IorD and MemRead.
    - Waits on mem_ready, then goes to MEM_WB.
  - MEM_WB: RegWrite, MemtoReg. Goes to FETCH.
  - MEM_WRITE:
    - Asserts IorD and MemWrite, held until mem_ready=1, then goes to FETCH.
    - MemWrite is never dropped while waiting.
  - R_EXEC: ALUSrcA=1, ALUop=010. Goes to R_WB.
  - R_WB: RegWrite, RegDst. Goes to FETCH.
  - I_EXEC:
    - ALUSrcA=1.
    - ALUSrcB=2 for addi/slti, 3 for andi/ori.
    - ALUop is 000/101/011/100 for addi/slti/andi/ori.
    - Goes to I_WB.
  - I_WB: RegWrite. Goes to FETCH.
  - BRANCH:
    - ALUSrcA=1, ALUop=001, PCSource=1.
    - PCWriteCond=1; the datapath writes the PC when (zero XOR bne).
    - Goes to FETCH.
  - JUMP: PCWrite, PCSource=2. Goes to FETCH.
- Illegal opcode in DECODE: go to FETCH, with no state-changing strobe issued.
- Reset:
  - reset=1 at a rising edge puts the FSM in FETCH, discarding any in-flight instruction, including a mid-MEM_WRITE.
  - While reset is high, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond and RegWrite are forced to 0, regardless of state.
  - After release, FETCH behaves normally on the first cycle.
- Latency per instruction (mem_ready always 1):
  - lw 5; sw, R-type and I-type 4; beq/bne and j 3.
- mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- When defined:
  - Adds output illegal_op (1 bit) and state TRAP.
  - An illegal opcode in DECODE goes to TRAP, which pulses illegal_op=1 for exactly one cycle and then goes to FETCH. Total cost is 3 cycles.
  - illegal_op resets to 0.
- When undefined: no port and no state; an illegal opcode goes straight from DECODE to FETCH.

Decomposition:
- Shared package mc_defs holds:
  - Opcode constants.
  - ALUop constants, shared with the ALU control block so both sides use one encoding.
  - State enumeration.
  - ALUSrcB and PCSource select constants.
- No sub-module is needed; the output decode sits in the same module as the state register.

Test Plan:
- Reset: hold reset 2 cycles with mem_ready=1 -> state_o=FETCH, and all write/read strobes 0 while reset is high. First cycle after release shows MemRead=1, ALUop=000.
- lw (opcode=0101), mem_ready=1 -> states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, FETCH. ALUop=000 in MEM_ADDR; RegWrite=1 and MemtoReg=1 only in MEM_WB.
- R-type (0000) then ori (0011) -> ALUop=010 in R_EXEC with RegDst=1 in R_WB. ALUop=100 and ALUSrcB=3 in I_EXEC.
- sw with mem_ready=0 for 3 cycles in MEM_WRITE -> MemWrite=1 for 4 consecutive cycles, then FETCH. A reset pulse injected in the 2nd wait cycle -> FETCH next cycle with MemWrite=0.
- beq (0111), zero=1, then j (1001) -> BRANCH shows ALUop=001, PCWriteCond=1, PCSource=1. JUMP shows PCWrite=1, PCSource=2. Each instruction takes 3 cycles.
- Illegal opcode 1100 -> DECODE returns to FETCH with no RegWrite/MemWrite/PCWrite. With MC_ILLEGAL_TRAP_EN defined, illegal_op=1 for exactly 1 cycle.

Source files
------------

// File: rtl/mc_defs.sv
// Shared encodings for the multicycle main control FSM and the ALU control block.
// Opcodes, ALUop codes, FSM states and datapath mux selects.
package mc_defs;

    localparam int OPW_D  = 4;
    localparam int AOPW_D = 3;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ANDI = 4'b0010;
    localparam logic [3:0] OP_ORI  = 4'b0011;
    localparam logic [3:0] OP_SLTI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_BEQ  = 4'b0111;
    localparam logic [3:0] OP_BNE  = 4'b1000;
    localparam logic [3:0] OP_J    = 4'b1001;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_FUNC = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;

    localparam logic [1:0] SRCB_REGB = 2'd0;
    localparam logic [1:0] SRCB_ONE  = 2'd1;
    localparam logic [1:0] SRCB_SEXT = 2'd2;
    localparam logic [1:0] SRCB_ZEXT = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

endpackage

// File: rtl/mc_main_control.sv
// Multicycle main control FSM: opcode decode, sequencing and datapath strobes.
// Optional MC_ILLEGAL_TRAP_EN adds a TRAP state and the illegal_op output.
module mc_main_control
    import mc_defs::*;
#(
    parameter int OPW  = OPW_D,
    parameter int AOPW = AOPW_D
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic [AOPW-1:0] ALUop,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            RegDst,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      PCSource,
`ifdef MC_ILLEGAL_TRAP_EN
    output logic            illegal_op,
`endif
    output logic [3:0]      state_o
);

    state_t state, state_nx;
    logic [2:0] aop;
    logic pcw, pcwc, mrd, mwr, irw, rgw;
    logic [3:0] op;

    // The branch condition is resolved in the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    assign op = 4'(opcode);

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_FETCH:     if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    OP_R:                        state_nx = S_R_EXEC;
                    OP_ADDI, OP_ANDI,
                    OP_ORI, OP_SLTI:             state_nx = S_I_EXEC;
                    OP_LW, OP_SW:                state_nx = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:              state_nx = S_BRANCH;
                    OP_J:                        state_nx = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:                     state_nx = S_TRAP;
`else
                    default:                     state_nx = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR:  state_nx = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) state_nx = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) state_nx = S_FETCH;
            S_R_EXEC:    state_nx = S_R_WB;
            S_I_EXEC:    state_nx = S_I_WB;
            default:     state_nx = S_FETCH;
        endcase
    end

    always_comb begin
        aop      = ALU_ADD;
        pcw      = 1'b0;
        pcwc     = 1'b0;
        mrd      = 1'b0;
        mwr      = 1'b0;
        irw      = 1'b0;
        rgw      = 1'b0;
        IorD     = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_REGB;
        PCSource = PCSRC_ALU;
        unique case (state)
            S_FETCH: begin
                mrd     = 1'b1;
                irw     = mem_ready;
                pcw     = mem_ready;
                ALUSrcB = SRCB_ONE;
            end
            S_DECODE:    ALUSrcB = SRCB_SEXT;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_SEXT;
            end
            S_MEM_READ: begin
                IorD = 1'b1;
                mrd  = 1'b1;
            end
            S_MEM_WB: begin
                rgw      = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WRITE: begin
                IorD = 1'b1;
                mwr  = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                aop     = ALU_FUNC;
            end
            S_R_WB: begin
                rgw    = 1'b1;
                RegDst = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                unique case (op)
                    OP_ANDI: begin
                        ALUSrcB = SRCB_ZEXT;
                        aop     = ALU_AND;
                    end
                    OP_ORI: begin
                        ALUSrcB = SRCB_ZEXT;
                        aop     = ALU_OR;
                    end
                    OP_SLTI: begin
                        ALUSrcB = SRCB_SEXT;
                        aop     = ALU_SLT;
                    end
                    default: begin
                        ALUSrcB = SRCB_SEXT;
                        aop     = ALU_ADD;
                    end
                endcase
            end
            S_I_WB:      rgw = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                aop      = ALU_SUB;
                PCSource = PCSRC_ALUOUT;
                pcwc     = 1'b1;
            end
            S_JUMP: begin
                pcw      = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    // Reset suppresses every strobe that can change architectural state.
    assign MemRead     = mrd  & ~reset;
    assign MemWrite    = mwr  & ~reset;
    assign IRWrite     = irw  & ~reset;
    assign PCWrite     = pcw  & ~reset;
    assign PCWriteCond = pcwc & ~reset;
    assign RegWrite    = rgw  & ~reset;
    assign ALUop       = AOPW'(aop);
    assign state_o     = state;

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal_op = (state == S_TRAP) & ~reset;
`endif

endmodule

// File: tb/tb_mc_main_control.sv
// Directed self-checking bench for mc_main_control.
// Walks reset, lw, R/ori, sw stalls with reset abort, beq/j and an illegal opcode.
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [2:0] ALUop;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] state_o;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mc_main_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .ALUop(ALUop), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource),
`ifdef MC_ILLEGAL_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .state_o(state_o)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        reset = 1'b1; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        chk("rst_state", 8'(state_o), 8'd0);
        chk("rst_memrd", 8'(MemRead), 8'd0);
        chk("rst_irw", 8'(IRWrite), 8'd0);
        chk("rst_pcw", 8'(PCWrite), 8'd0);
        chk("rst_memwr", 8'(MemWrite), 8'd0);
        chk("rst_rgw", 8'(RegWrite), 8'd0);
        chk("rst_pcwc", 8'(PCWriteCond), 8'd0);

        reset = 1'b0; mem_ready = 1'b0; #1;
        chk("fetch_memrd", 8'(MemRead), 8'd1);
        chk("fetch_aluop", 8'(ALUop), 8'd0);
        chk("fetch_stall_irw", 8'(IRWrite), 8'd0);
        chk("fetch_stall_pcw", 8'(PCWrite), 8'd0);
        tick();
        chk("fetch_stall_state", 8'(state_o), 8'd0);
        mem_ready = 1'b1; opcode = 4'b0101; #1;
        chk("fetch_irw", 8'(IRWrite), 8'd1);
        chk("fetch_pcw", 8'(PCWrite), 8'd1);
        chk("fetch_srcb", 8'(ALUSrcB), 8'd1);

        tick();
        chk("lw_decode", 8'(state_o), 8'd1);
        chk("lw_decode_srcb", 8'(ALUSrcB), 8'd2);
        tick();
        chk("lw_maddr", 8'(state_o), 8'd2);
        chk("lw_maddr_aluop", 8'(ALUop), 8'd0);
        chk("lw_maddr_srca", 8'(ALUSrcA), 8'd1);
        chk("lw_maddr_rgw", 8'(RegWrite), 8'd0);
        tick();
        chk("lw_mread", 8'(state_o), 8'd3);
        chk("lw_mread_iord", 8'(IorD), 8'd1);
        chk("lw_mread_memrd", 8'(MemRead), 8'd1);
        chk("lw_mread_m2r", 8'(MemtoReg), 8'd0);
        tick();
        chk("lw_mwb", 8'(state_o), 8'd4);
        chk("lw_mwb_rgw", 8'(RegWrite), 8'd1);
        chk("lw_mwb_m2r", 8'(MemtoReg), 8'd1);
        opcode = 4'b0000;
        tick();
        chk("lw_done", 8'(state_o), 8'd0);
        chk("lw_done_rgw", 8'(RegWrite), 8'd0);

        tick(); tick();
        chk("r_exec", 8'(state_o), 8'd6);
        chk("r_exec_aluop", 8'(ALUop), 8'd2);
        chk("r_exec_srcb", 8'(ALUSrcB), 8'd0);
        tick();
        chk("r_wb", 8'(state_o), 8'd7);
        chk("r_wb_regdst", 8'(RegDst), 8'd1);
        chk("r_wb_rgw", 8'(RegWrite), 8'd1);
        opcode = 4'b0011;
        tick();
        chk("r_done", 8'(state_o), 8'd0);

        tick(); tick();
        chk("ori_exec", 8'(state_o), 8'd8);
        chk("ori_aluop", 8'(ALUop), 8'd4);
        chk("ori_srcb", 8'(ALUSrcB), 8'd3);
        tick();
        chk("ori_wb", 8'(state_o), 8'd9);
        chk("ori_wb_rgw", 8'(RegWrite), 8'd1);
        chk("ori_wb_regdst", 8'(RegDst), 8'd0);
        opcode = 4'b0110;
        tick();
        chk("ori_done", 8'(state_o), 8'd0);

        tick(); tick(); tick();
        chk("sw_mwrite", 8'(state_o), 8'd5);
        mem_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            if (MemWrite === 1'b1) cnt++;
            if (i < 3) tick();
        end
        chk("sw_memwr_cycles", 8'(cnt), 8'd4);
        chk("sw_iord", 8'(IorD), 8'd1);
        tick();
        chk("sw_done", 8'(state_o), 8'd0);
        chk("sw_done_memwr", 8'(MemWrite), 8'd0);

        tick(); tick(); tick();
        chk("sw2_mwrite", 8'(state_o), 8'd5);
        mem_ready = 1'b0;
        tick();
        reset = 1'b1; #1;
        chk("sw2_rst_memwr", 8'(MemWrite), 8'd0);
        tick();
        reset = 1'b0; mem_ready = 1'b1; opcode = 4'b0111; zero = 1'b1; #1;
        chk("sw2_abort_state", 8'(state_o), 8'd0);
        chk("sw2_abort_memwr", 8'(MemWrite), 8'd0);

        tick(); tick();
        chk("beq_branch", 8'(state_o), 8'd10);
        chk("beq_aluop", 8'(ALUop), 8'd1);
        chk("beq_pcwc", 8'(PCWriteCond), 8'd1);
        chk("beq_pcsrc", 8'(PCSource), 8'd1);
        chk("beq_srca", 8'(ALUSrcA), 8'd1);
        opcode = 4'b1001;
        tick();
        chk("beq_done", 8'(state_o), 8'd0);

        tick(); tick();
        chk("j_jump", 8'(state_o), 8'd11);
        chk("j_pcw", 8'(PCWrite), 8'd1);
        chk("j_pcsrc", 8'(PCSource), 8'd2);
        opcode = 4'b1100;
        tick();
        chk("j_done", 8'(state_o), 8'd0);

        tick();
        chk("ill_decode", 8'(state_o), 8'd1);
        chk("ill_rgw", 8'(RegWrite), 8'd0);
        chk("ill_memwr", 8'(MemWrite), 8'd0);
        chk("ill_pcw", 8'(PCWrite), 8'd0);
        tick();
`ifdef MC_ILLEGAL_TRAP_EN
        chk("ill_trap", 8'(state_o), 8'd12);
        chk("ill_flag", 8'(illegal_op), 8'd1);
        chk("ill_trap_rgw", 8'(RegWrite), 8'd0);
        tick();
        chk("ill_flag_clr", 8'(illegal_op), 8'd0);
`endif
        chk("ill_back", 8'(state_o), 8'd0);
        chk("ill_back_memrd", 8'(MemRead), 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
